mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the instruction-fetch (IF) stage and the data-memory (MEM) stage of the 5-stage pipeline.
- Serialises their word accesses with a request/acknowledge handshake towards memory.
- Generates per-stage stall signals and per-stage done pulses with registered read data.
- Data accesses (LD/ST) win by default; a burst limit stops fetch starvation. A watchdog recovers from a memory that never acknowledges.

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default sizing for the IF/MEM unified-memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int N            = 32;
    localparam int MAX_DM_BURST = 4;
    localparam int MEM_TIMEOUT  = 64;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_IF,
        ARB_DM,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and data accesses onto one single-ported memory,
// with data priority, a fetch anti-starvation burst limit and an ack watchdog.
module mem_port_arbiter #(
    parameter int N            = mem_port_arbiter_pkg::N,
    parameter int MAX_DM_BURST = mem_port_arbiter_pkg::MAX_DM_BURST,
    parameter int MEM_TIMEOUT  = mem_port_arbiter_pkg::MEM_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         if_req,
    input  logic [N-1:0] if_addr,
    input  logic         flush,
    output logic [N-1:0] if_rdata,
    output logic         if_done,
    output logic         if_stall,
    input  logic         dm_req,
    input  logic         dm_we,
    input  logic [N-1:0] dm_addr,
    input  logic [N-1:0] dm_wdata,
    output logic [N-1:0] dm_rdata,
    output logic         dm_done,
    output logic         dm_stall,
    output logic         err,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata,
    input  logic         mem_ack
);
    import mem_port_arbiter_pkg::*;

    localparam int BW = $clog2(MAX_DM_BURST + 1);
    localparam int WW = $clog2(MEM_TIMEOUT);
    localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_DM_BURST);
    localparam logic [WW-1:0] WD_LAST    = WW'(MEM_TIMEOUT - 1);
    localparam logic [N-1:0]  ALIGN_MASK = ~N'(3);

    arb_state_t    state_q, state_d;
    arb_owner_t    owner_q, owner_d;
    logic [N-1:0]  addr_q, addr_d;
    logic          we_q, we_d;
    logic [N-1:0]  wdata_q, wdata_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          discard_q, discard_d;
    logic          err_q, err_d;
    logic [N-1:0]  if_rdata_q, if_rdata_d;
    logic [N-1:0]  dm_rdata_q, dm_rdata_d;
    logic          if_done_q, if_done_d;
    logic          dm_done_q, dm_done_d;

    logic dm_grant;
    logic if_grant;

    // Data wins unless it has already taken MAX_DM_BURST grants past a waiting fetch.
    assign dm_grant = (state_q == ARB_IDLE) && dm_req && ((burst_q < BURST_MAX) || !if_req);
    assign if_grant = (state_q == ARB_IDLE) && !dm_grant && if_req && !flush;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        burst_d    = burst_q;
        wd_d       = wd_q;
        discard_d  = discard_q;
        err_d      = err_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_done_d  = 1'b0;
        dm_done_d  = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (dm_grant) begin
                    state_d = ARB_DM;
                    owner_d = OWN_DM;
                    addr_d  = dm_addr;
                    we_d    = dm_we;
                    wdata_d = dm_wdata;
                end else if (if_grant) begin
                    state_d = ARB_IF;
                    owner_d = OWN_IF;
                    addr_d  = if_addr;
                    we_d    = 1'b0;
                    wdata_d = '0;
                end
            end
            ARB_IF, ARB_DM: begin
                wd_d = wd_q + WW'(1);
                if (owner_q == OWN_IF && flush) begin
                    discard_d = 1'b1;
                end
                // An ack in the last watchdog cycle still counts as a normal completion.
                if (mem_ack || wd_q == WD_LAST) begin
                    state_d = ARB_RESP;
                    wd_d    = '0;
                    err_d   = !mem_ack;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = mem_ack ? mem_rdata : '0;
                        if_done_d  = !discard_d;
                    end else begin
                        if (!mem_ack || !we_q) begin
                            dm_rdata_d = mem_ack ? mem_rdata : '0;
                        end
                        dm_done_d = 1'b1;
                    end
                end
            end
            ARB_RESP: begin
                state_d   = ARB_IDLE;
                discard_d = 1'b0;
                err_d     = 1'b0;
            end
            default: state_d = ARB_IDLE;
        endcase

        if (!if_req || if_grant) begin
            burst_d = '0;
        end else if (dm_grant && burst_q != BURST_MAX) begin
            burst_d = burst_q + BW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWN_IF;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            burst_q    <= '0;
            wd_q       <= '0;
            discard_q  <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            burst_q    <= burst_d;
            wd_q       <= wd_d;
            discard_q  <= discard_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_done_q  <= if_done_d;
            dm_done_q  <= dm_done_d;
        end
    end

    assign mem_req   = (state_q == ARB_IF) || (state_q == ARB_DM);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = mem_req ? (addr_q & ALIGN_MASK) : '0;
    assign mem_wdata = mem_req ? wdata_q : '0;

    // A flush landing in the response cycle still cancels the fetch completion.
    assign if_done  = if_done_q & ~flush;
    assign dm_done  = dm_done_q;
    assign err      = err_q;
    assign if_rdata = if_rdata_q;
    assign dm_rdata = dm_rdata_q;
    assign if_stall = if_req & ~if_done;
    assign dm_stall = dm_req & ~dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, corner-case sequences
// and randomized rounds against a word-memory reference model.
module tb_mem_port_arbiter;
    localparam int N  = 32;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         if_req, flush, dm_req, dm_we;
    logic [N-1:0] if_addr, dm_addr, dm_wdata;
    logic [N-1:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic [N-1:0] mem_rdata = '0;
    logic         mem_ack = 1'b0;
    logic         if_done, if_stall, dm_done, dm_stall, err, mem_req, mem_we;

    int total = 0;
    int bad   = 0;

    int  mem_lat = 0;
    bit  mem_en  = 1'b1;
    int  mem_cnt = 0;
    logic [31:0] mem_arr [256];
    logic [31:0] ref_mem [256];

    typedef struct {
        bit          dm;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] exp_maddr;
        int          exp_cyc;
        logic [31:0] exp_rd;
    } vec_t;

    always #5 clk = ~clk;

    mem_port_arbiter #(.N(N), .MAX_DM_BURST(4), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .flush(flush),
        .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
        .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    // Memory responder: acks after mem_lat extra cycles of a held request.
    always begin
        @(posedge clk);
        #2;
        if (mem_req && mem_en && mem_cnt >= mem_lat) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_arr[mem_addr[9:2]];
            if (mem_we) mem_arr[mem_addr[9:2]] = mem_wdata;
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
        end
        mem_cnt = mem_req ? mem_cnt + 1 : 0;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "bench timeout");
    end

    function automatic logic [31:0] pat(input int w);
        return 32'h1000_0000 + 32'(w);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drives one or both requesters, each held until its done, and reports what it saw.
    task automatic run_round(input bit if_on, input bit dm_on, input logic [31:0] ia,
                             input logic [31:0] da, input logic [31:0] dwd, input bit dwe,
                             output int if_cyc, output int dm_cyc,
                             output logic [31:0] if_rd, output logic [31:0] dm_rd,
                             output logic [31:0] first_addr, output bit first_we,
                             output bit err_seen, output int stall_bad);
        int cyc = 0;
        bit if_pend, dm_pend, got_first;
        if_cyc = 0; dm_cyc = 0; if_rd = '0; dm_rd = '0;
        first_addr = '0; first_we = 1'b0; err_seen = 1'b0; stall_bad = 0; got_first = 1'b0;
        @(posedge clk); #1;
        if_req = if_on; if_addr = ia;
        dm_req = dm_on; dm_addr = da; dm_we = dwe; dm_wdata = dwd;
        if_pend = if_on; dm_pend = dm_on;
        while ((if_pend || dm_pend) && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (mem_req && !got_first) begin
                got_first = 1'b1; first_addr = mem_addr; first_we = mem_we;
            end
            if (err) err_seen = 1'b1;
            if (if_pend && !if_done && !if_stall) stall_bad++;
            if (dm_pend && !dm_done && !dm_stall) stall_bad++;
            if (if_pend && if_done) begin if_pend = 1'b0; if_cyc = cyc; if_rd = if_rdata; end
            if (dm_pend && dm_done) begin dm_pend = 1'b0; dm_cyc = cyc; dm_rd = dm_rdata; end
            @(posedge clk); #1;
            if (!if_pend) if_req = 1'b0;
            if (!dm_pend) dm_req = 1'b0;
        end
        if_req = 1'b0;
        dm_req = 1'b0;
    endtask

    initial begin
        vec_t vecs[8];
        int if_cyc, dm_cyc, sbad, cyc, ng, reqc, naccess, kind, lat, exp_if_cyc;
        logic [31:0] if_rd, dm_rd, faddr, rd, ia, da, dwd, exp_dm_rd, exp_if_rd, last_dm, last_addr;
        bit fwe, errs, got, prev, drop_if, e, ion, don, dwe;
        bit grants[6];

        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = pat(i);
            ref_mem[i] = pat(i);
        end
        rst = 1'b1; if_req = 1'b0; flush = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_dm_rdata", dm_rdata, 32'h0);
        check("rst_flags", {25'h0, if_done, if_stall, dm_done, dm_stall, err, mem_req, mem_we}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        // Single-access vector table
        vecs[0] = '{1'b0, 1'b0, 32'h040, 32'h0,         0, 32'h040, 3,  32'h1000_0010};
        vecs[1] = '{1'b1, 1'b0, 32'h103, 32'h0,         1, 32'h100, 4,  32'h1000_0040};
        vecs[2] = '{1'b1, 1'b1, 32'h022, 32'hDEAD_BEEF, 0, 32'h020, 3,  32'h1000_0040};
        vecs[3] = '{1'b0, 1'b0, 32'h022, 32'h0,         2, 32'h020, 5,  32'hDEAD_BEEF};
        vecs[4] = '{1'b1, 1'b0, 32'h021, 32'h0,         3, 32'h020, 6,  32'hDEAD_BEEF};
        vecs[5] = '{1'b0, 1'b0, 32'h3FC, 32'h0,         6, 32'h3FC, 9,  32'h1000_00FF};
        vecs[6] = '{1'b1, 1'b0, 32'h080, 32'h0,         7, 32'h080, 10, 32'h1000_0020};
        vecs[7] = '{1'b0, 1'b0, 32'h081, 32'h0,         7, 32'h080, 10, 32'h1000_0020};
        for (int i = 0; i < 8; i++) begin
            mem_lat = vecs[i].lat;
            run_round(!vecs[i].dm, vecs[i].dm, vecs[i].addr, vecs[i].addr, vecs[i].wdata, vecs[i].we,
                      if_cyc, dm_cyc, if_rd, dm_rd, faddr, fwe, errs, sbad);
            if (vecs[i].dm && vecs[i].we) ref_mem[vecs[i].addr[9:2]] = vecs[i].wdata;
            check($sformatf("v%0d_cycles", i), vecs[i].dm ? dm_cyc : if_cyc, vecs[i].exp_cyc);
            check($sformatf("v%0d_mem_addr", i), faddr, vecs[i].exp_maddr);
            check($sformatf("v%0d_mem_we", i), 32'(fwe), 32'(vecs[i].dm & vecs[i].we));
            check($sformatf("v%0d_rdata", i), vecs[i].dm ? dm_rd : if_rd, vecs[i].exp_rd);
            check($sformatf("v%0d_err", i), 32'(errs), 32'h0);
            check($sformatf("v%0d_stall", i), sbad, 0);
            $display("vec %0d: dm=%0d we=%0d addr=%h lat=%0d cycles=%0d", i, vecs[i].dm, vecs[i].we,
                     vecs[i].addr, vecs[i].lat, vecs[i].dm ? dm_cyc : if_cyc);
        end

        // Both requesting: the store goes first, then the fetch
        mem_lat = 0;
        run_round(1'b1, 1'b1, 32'h300, 32'h103, 32'h1234_5678, 1'b1,
                  if_cyc, dm_cyc, if_rd, dm_rd, faddr, fwe, errs, sbad);
        ref_mem[8'h40] = 32'h1234_5678;
        check("prio_first_addr", faddr, 32'h100);
        check("prio_first_we", 32'(fwe), 32'h1);
        check("prio_dm_cycles", dm_cyc, 3);
        check("prio_if_cycles", if_cyc, 6);
        check("prio_if_rdata", if_rd, 32'h1000_00C0);
        $display("prio: dm_done at %0d, if_done at %0d", dm_cyc, if_cyc);

        // Burst limit: four data grants, one fetch, then data again
        @(posedge clk); #1;
        if_addr = 32'h300; dm_addr = 32'h200; dm_we = 1'b0;
        if_req = 1'b1; dm_req = 1'b1;
        ng = 0; prev = 1'b0; cyc = 0;
        while (ng < 6 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (mem_req && !prev) begin grants[ng] = (mem_addr == 32'h300); ng++; end
            prev = mem_req;
            drop_if = if_done;
            @(posedge clk); #1;
            if (drop_if) if_req = 1'b0;
        end
        got = 1'b0; cyc = 0;
        while (!got && cyc < 30) begin
            @(negedge clk); cyc++;
            got = dm_done;
        end
        @(posedge clk); #1 dm_req = 1'b0; if_req = 1'b0;
        check("burst_grants", ng, 6);
        for (int i = 0; i < 6; i++) check($sformatf("burst_g%0d_is_if", i), 32'(grants[i]), (i == 4) ? 32'h1 : 32'h0);
        $display("burst: %0d grants, fetch at slot 4 = %0d", ng, grants[4]);

        // Flush while fetch is at memory: result discarded, redirected fetch completes
        mem_lat = 2;
        @(posedge clk); #1 if_req = 1'b1; if_addr = 32'h040;
        cyc = 0; naccess = 0; prev = 1'b0;
        while (!mem_req && cyc < 10) begin @(negedge clk); cyc++; end
        if (mem_req) begin naccess = 1; prev = 1'b1; end
        @(posedge clk); #1 flush = 1'b1; if_addr = 32'h080;
        @(posedge clk); #1 flush = 1'b0;
        got = 1'b0; sbad = 0; cyc = 0; rd = '0; last_addr = '0;
        while (!got && cyc < 40) begin
            @(negedge clk); cyc++;
            if (mem_req && !prev) naccess++;
            if (mem_req) last_addr = mem_addr;
            prev = mem_req;
            if (if_done) begin got = 1'b1; rd = if_rdata; end
            else if (!if_stall) sbad++;
        end
        @(posedge clk); #1 if_req = 1'b0;
        check("flush_got_done", 32'(got), 32'h1);
        check("flush_rdata", rd, 32'h1000_0020);
        check("flush_accesses", naccess, 2);
        check("flush_last_addr", last_addr, 32'h080);
        check("flush_stall_held", sbad, 0);
        $display("flush_if: accesses=%0d rdata=%h", naccess, rd);

        // Flush in the response cycle
        mem_lat = 0;
        @(posedge clk); #1 if_req = 1'b1; if_addr = 32'h040;
        @(posedge clk); #1;
        @(posedge clk); #1 flush = 1'b1;
        @(negedge clk);
        check("flush_resp_done", 32'(if_done), 32'h0);
        check("flush_resp_stall", 32'(if_stall), 32'h1);
        @(posedge clk); #1 flush = 1'b0;
        got = 1'b0; cyc = 0; rd = '0;
        while (!got && cyc < 20) begin
            @(negedge clk); cyc++;
            if (if_done) begin got = 1'b1; rd = if_rdata; end
        end
        @(posedge clk); #1 if_req = 1'b0;
        check("flush_resp_refetch", rd, 32'h1000_0010);
        $display("flush_resp: refetch rdata=%h", rd);

        // Watchdog: memory never acks a load
        mem_en = 1'b0;
        @(posedge clk); #1 dm_req = 1'b1; dm_addr = 32'h044; dm_we = 1'b0;
        reqc = 0; got = 1'b0; cyc = 0; e = 1'b0; rd = 32'hFFFF_FFFF;
        while (!got && cyc < 40) begin
            @(negedge clk); cyc++;
            if (mem_req) reqc++;
            if (dm_done) begin got = 1'b1; e = err; rd = dm_rdata; end
        end
        @(posedge clk); #1 dm_req = 1'b0; mem_en = 1'b1;
        check("wd_req_cycles", reqc, TO);
        check("wd_done", 32'(got), 32'h1);
        check("wd_err", 32'(e), 32'h1);
        check("wd_rdata", rd, 32'h0);
        $display("timeout: mem_req cycles=%0d err=%0d", reqc, e);

        // Asynchronous reset during a data access
        mem_lat = 5;
        @(posedge clk); #1 dm_req = 1'b1; dm_addr = 32'h010; dm_we = 1'b0;
        cyc = 0;
        while (!mem_req && cyc < 10) begin @(negedge clk); cyc++; end
        check("rst_mid_saw_req", 32'(mem_req), 32'h1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_mem_req", 32'(mem_req), 32'h0);
        check("rst_mid_done", {30'h0, dm_done, if_done}, 32'h0);
        check("rst_mid_dm_rdata", dm_rdata, 32'h0);
        @(posedge clk); #1 dm_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        mem_lat = 0;
        run_round(1'b1, 1'b0, 32'h048, 32'h0, 32'h0, 1'b0,
                  if_cyc, dm_cyc, if_rd, dm_rd, faddr, fwe, errs, sbad);
        check("rst_after_cycles", if_cyc, 3);
        check("rst_after_rdata", if_rd, 32'h1000_0012);
        $display("reset_mid: fetch after reset cycles=%0d", if_cyc);

        // Randomized rounds against the word-memory model
        last_dm = 32'h0;
        for (int r = 0; r < 30; r++) begin
            kind = int'($urandom_range(0, 2));
            ion = (kind != 1);
            don = (kind != 0);
            lat = int'($urandom_range(0, 6));
            ia = 32'($urandom_range(0, 1023));
            da = 32'($urandom_range(0, 1023));
            dwe = 1'($urandom_range(0, 1));
            dwd = $urandom;
            exp_dm_rd = last_dm;
            if (don) begin
                if (dwe) ref_mem[da[9:2]] = dwd;
                else     exp_dm_rd = ref_mem[da[9:2]];
            end
            exp_if_rd = ref_mem[ia[9:2]];
            exp_if_cyc = (ion && don) ? 2 * (lat + 3) : lat + 3;
            mem_lat = lat;
            run_round(ion, don, ia, da, dwd, dwe, if_cyc, dm_cyc, if_rd, dm_rd, faddr, fwe, errs, sbad);
            check($sformatf("r%0d_first_addr", r), faddr, (don ? da : ia) & 32'hFFFF_FFFC);
            check($sformatf("r%0d_err", r), 32'(errs), 32'h0);
            if (don) begin
                check($sformatf("r%0d_dm_cycles", r), dm_cyc, lat + 3);
                check($sformatf("r%0d_dm_rdata", r), dm_rd, exp_dm_rd);
                last_dm = exp_dm_rd;
            end
            if (ion) begin
                check($sformatf("r%0d_if_cycles", r), if_cyc, exp_if_cyc);
                check($sformatf("r%0d_if_rdata", r), if_rd, exp_if_rd);
            end
            $display("rand %0d: if=%0d dm=%0d we=%0d lat=%0d ia=%h da=%h", r, ion, don, dwe, lat, ia, da);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
